// File: rtl/des_entry_sequencer.sv
// ---------------------------------------------------------------------------
// des_entry_sequencer
//
// Front-panel controller for the DES demo board. Runs the 16-nibble switch
// entry block twice: first to capture the 64-bit key, then the 64-bit data
// block. It then launches the DES core, waits for completion with a timeout,
// and holds the result for the display logic.
//
// Ports
//   clk, rst          system clock (posedge) / asynchronous active-low reset
//   go_btn_n          raw "go" pushbutton, active-low, asynchronous to clk
//   mode_sw           0 = encrypt, 1 = decrypt, sampled when the data is loaded
//   entry_values      64-bit value bus from the entry block
//   entry_count       nibbles entered so far (0..16)
//   entry_clr_n       active-low clear to the entry block
//   des_key/des_block key and data registers driving the DES core
//   des_decrypt       direction to the DES core
//   des_start         single-cycle start pulse
//   des_done          completion from the core, honoured only while waiting
//   des_result        core output, captured on the des_done cycle
//   result            held result for display
//   result_valid      high while a fresh result is shown
//   error             high while in the timeout error state
//   state_dbg         current state encoding, for LEDs
// ---------------------------------------------------------------------------
module des_entry_sequencer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TIMEOUT_CYCLES  = 1024,  // must be >= 2
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go_btn_n,
    input  logic        mode_sw,
    input  logic [63:0] entry_values,
    input  logic [4:0]  entry_count,
    output logic        entry_clr_n,
    output logic [63:0] des_key,
    output logic [63:0] des_block,
    output logic        des_decrypt,
    output logic        des_start,
    input  logic        des_done,
    input  logic [63:0] des_result,
    output logic [63:0] result,
    output logic        result_valid,
    output logic        error,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] S_CLR_KEY = 3'd0;
    localparam logic [2:0] S_KEY     = 3'd1;
    localparam logic [2:0] S_CLR_DAT = 3'd2;
    localparam logic [2:0] S_DAT     = 3'd3;
    localparam logic [2:0] S_START   = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;
    localparam logic [2:0] S_SHOW    = 3'd6;
    localparam logic [2:0] S_ERR     = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // go button: synchronizer + debounce
    // ------------------------------------------------------------------
    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             go_press;

    // Button idles high, so the synchronizer and stable level reset to 1;
    // otherwise the first release after reset would look like a level change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= go_btn_n;
            sync2_q <= sync1_q;
        end
    end

    // db_cnt counts consecutive samples that differ from the stable level.
    // The DEBOUNCE_CYCLES-th differing sample commits the new level; a
    // matching sample restarts the count. Only a commit to 0 is a press, so
    // holding the button can never produce a second pulse.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        go_press = 1'b0;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = sync2_q;
                go_press = ~sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_q <= 1'b1;
            db_cnt_q <= '0;
        end else begin
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    logic [2:0]       state_q, state_d;
    logic [63:0]      key_q, key_d;
    logic [63:0]      blk_q, blk_d;
    logic [63:0]      res_q, res_d;
    logic             dec_q, dec_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] to_cnt_inc;
    logic             entry_full;

    assign entry_full = (entry_count == 5'd16);
    assign to_cnt_inc = to_cnt_q + CNT_ONE;

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        blk_d    = blk_q;
        res_d    = res_q;
        dec_d    = dec_q;
        to_cnt_d = to_cnt_q;
        case (state_q)
            S_CLR_KEY: state_d = S_KEY;
            S_KEY: begin
                if (go_press && entry_full) begin
                    key_d   = entry_values;
                    state_d = S_CLR_DAT;
                end
            end
            S_CLR_DAT: state_d = S_DAT;
            S_DAT: begin
                if (go_press && entry_full) begin
                    blk_d   = entry_values;
                    dec_d   = mode_sw;
                    state_d = S_START;
                end
            end
            S_START: begin
                to_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // START counts as the first cycle of the budget, so WAIT
                // lasts TIMEOUT_CYCLES-1 cycles and error rises exactly
                // TIMEOUT_CYCLES cycles after des_start. done is tested
                // first so it wins on the final cycle.
                to_cnt_d = to_cnt_inc;
                if (des_done) begin
                    res_d   = des_result;
                    state_d = S_SHOW;
                end else if (to_cnt_inc == TO_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_SHOW: begin
                // Re-run with the same key: only the data block is re-entered.
                if (go_press) state_d = S_CLR_DAT;
            end
            S_ERR: begin
                if (go_press) state_d = S_CLR_KEY;
            end
            default: state_d = S_CLR_KEY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_CLR_KEY;
            key_q    <= '0;
            blk_q    <= '0;
            res_q    <= '0;
            dec_q    <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            blk_q    <= blk_d;
            res_q    <= res_d;
            dec_q    <= dec_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Status outputs are plain decodes of the state register, which gives
    // the exact one-cycle clear/start pulses and the reset values for free.
    assign entry_clr_n  = ~((state_q == S_CLR_KEY) || (state_q == S_CLR_DAT));
    assign des_start    = (state_q == S_START);
    assign result_valid = (state_q == S_SHOW);
    assign error        = (state_q == S_ERR);
    assign state_dbg    = state_q;
    assign des_key      = key_q;
    assign des_block    = blk_q;
    assign des_decrypt  = dec_q;
    assign result       = res_q;

endmodule

// File: tb/tb_des_entry_sequencer.sv
module tb_des_entry_sequencer;

    localparam int D = 8;    // debounce cycles
    localparam int T = 16;   // timeout cycles

    localparam logic [63:0] KEY   = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY2  = 64'hA5A5_0F0F_1234_5678;
    localparam logic [63:0] DATA  = 64'h0123456789ABCDEF;
    localparam logic [63:0] DATA2 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] RESP  = 64'h85E813540F0AB405;
    localparam logic [63:0] RESP2 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] RESP3 = 64'h9999_8888_7777_6666;
    localparam logic [63:0] RESP4 = 64'hDEAD_BEEF_CAFE_F00D;

    logic        clk = 1'b0;
    logic        rst;
    logic        go_btn_n;
    logic        mode_sw;
    logic [63:0] entry_values;
    logic [4:0]  entry_count;
    logic        entry_clr_n;
    logic [63:0] des_key, des_block, des_result, result;
    logic        des_decrypt, des_start, des_done, result_valid, error;
    logic [2:0]  state_dbg;

    always #5 clk = ~clk;

    des_entry_sequencer #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T), .CNT_W(20)) dut (
        .clk(clk), .rst(rst), .go_btn_n(go_btn_n), .mode_sw(mode_sw),
        .entry_values(entry_values), .entry_count(entry_count),
        .entry_clr_n(entry_clr_n), .des_key(des_key), .des_block(des_block),
        .des_decrypt(des_decrypt), .des_start(des_start), .des_done(des_done),
        .des_result(des_result), .result(result), .result_valid(result_valid),
        .error(error), .state_dbg(state_dbg)
    );

    int n_chk = 0;
    int n_pass = 0;
    int tcyc = 0;
    bit cmp_en = 0;

    always @(posedge clk) tcyc <= tcyc + 1;

    // ---------------- DES core stand-in ----------------
    int          core_lat = 0;   // 0 = never answers
    logic [63:0] core_resp = '0;
    logic        core_done = 1'b0;
    logic        extra_done = 1'b0;
    int          pend = 0;

    always @(negedge clk) begin
        core_done = 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            core_done = (pend == 0);
        end
        if (des_start && core_lat > 0) pend = core_lat;
    end
    assign des_done   = core_done | extra_done;
    assign des_result = core_resp;

    // ---------------- behavioural model ----------------
    int          m_state;
    logic [63:0] m_key, m_blk, m_res;
    logic        m_dec;
    logic        m_stable;
    logic        hist [0:D];   // hist[0] = button at previous edge
    int          m_cyc, t_start;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state = 0; m_key = '0; m_blk = '0; m_res = '0; m_dec = 1'b0;
            m_stable = 1'b1; m_cyc = 0; t_start = 0;
            for (int i = 0; i <= D; i++) hist[i] = 1'b1;
        end else begin
            bit press, all_diff;
            int ns;
            // The button reaches the debouncer two edges late; a level is
            // accepted once the last D delayed samples all disagree with it.
            press = 0;
            all_diff = 1;
            for (int i = 1; i <= D; i++) if (hist[i] == m_stable) all_diff = 0;
            if (all_diff) begin
                m_stable = ~m_stable;
                press = (m_stable == 1'b0);
            end
            for (int i = D; i >= 1; i--) hist[i] = hist[i-1];
            hist[0] = go_btn_n;

            ns = m_state;
            case (m_state)
                0: ns = 1;
                1: if (press && entry_count == 16) begin m_key = entry_values; ns = 2; end
                2: ns = 3;
                3: if (press && entry_count == 16) begin
                       m_blk = entry_values; m_dec = mode_sw; ns = 4;
                   end
                4: begin t_start = m_cyc; ns = 5; end
                5: if (des_done) begin m_res = des_result; ns = 6; end
                   else if (m_cyc + 1 - t_start == T) ns = 7;
                6: if (press) ns = 2;
                7: if (press) ns = 0;
                default: ns = 0;
            endcase
            m_state = ns;
            m_cyc = m_cyc + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [200:0] exp_v, act_v;
            exp_v = {m_state[2:0], !(m_state == 0 || m_state == 2), m_state == 4,
                     m_state == 6, m_state == 7, m_dec, m_key, m_blk, m_res};
            act_v = {state_dbg, entry_clr_n, des_start, result_valid, error,
                     des_decrypt, des_key, des_block, result};
            n_chk++;
            if (exp_v === act_v) n_pass++;
            else $display("FAIL model t=%0t got st=%0d clr=%b st=%b rv=%b err=%b dec=%b key=%h blk=%h res=%h want st=%0d key=%h blk=%h res=%h",
                          $time, state_dbg, entry_clr_n, des_start, result_valid, error,
                          des_decrypt, des_key, des_block, result, m_state, m_key, m_blk, m_res);
        end
    end

    // ---------------- literal checks and stimulus ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h want=%h", name, got, exp);
    endtask

    int clr_lows, starts, start_cyc, err_cyc;
    bit saw0;

    // Holds the button low then high, sampling outputs every cycle.
    task automatic press(input int lo, input int hi);
        clr_lows = 0; starts = 0; start_cyc = -1; err_cyc = -1; saw0 = 0;
        for (int i = 0; i < lo + hi; i++) begin
            go_btn_n = (i < lo) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (!entry_clr_n) clr_lows++;
            if (des_start) begin starts++; start_cyc = tcyc; end
            if (error && err_cyc < 0) err_cyc = tcyc;
            if (state_dbg == 3'd0) saw0 = 1;
        end
    endtask

    initial begin
        rst = 1'b0; go_btn_n = 1'b1; mode_sw = 1'b0;
        entry_values = '0; entry_count = 5'd0;
        repeat (3) @(negedge clk);
        check("reset_state", 64'(state_dbg), 64'd0);
        check("reset_clr_n", 64'(entry_clr_n), 64'd0);
        check("reset_key", des_key, 64'd0);
        check("reset_flags", {61'd0, result_valid, error, des_start}, 64'd0);
        cmp_en = 1;
        rst = 1'b1;
        @(negedge clk);

        // Short entry: press ignored
        entry_count = 5'd9; entry_values = KEY2;
        press(3*D, 3*D);
        check("short_key", des_key, 64'd0);
        check("short_state", 64'(state_dbg), 64'd1);

        // Key capture
        entry_count = 5'd16; entry_values = KEY;
        press(3*D, 3*D);
        check("key_load", des_key, KEY);
        check("key_clr_pulse", 64'(clr_lows), 64'd1);
        check("key_state", 64'(state_dbg), 64'd3);

        // Known-answer run
        entry_values = DATA; mode_sw = 1'b0; core_lat = 3; core_resp = RESP;
        press(3*D, 3*D);
        check("kat_starts", 64'(starts), 64'd1);
        check("kat_result", result, RESP);
        check("kat_valid", 64'(result_valid), 64'd1);
        check("kat_block", des_block, DATA);

        // Re-run with same key, no core answer -> timeout
        press(3*D, 3*D);
        check("rerun_state", 64'(state_dbg), 64'd3);
        core_lat = 0; mode_sw = 1'b1; entry_values = DATA2;
        press(3*D, 3*D);
        check("timeout_dist", 64'(err_cyc - start_cyc), 64'(T));
        check("timeout_err", 64'(error), 64'd1);
        check("timeout_dec", 64'(des_decrypt), 64'd1);
        check("timeout_res_kept", result, RESP);
        press(3*D, 3*D);
        check("err_restart_saw0", 64'(saw0), 64'd1);
        check("err_restart_state", 64'(state_dbg), 64'd1);

        // done on the last waiting cycle beats the timeout
        entry_values = KEY; press(3*D, 3*D);
        entry_values = DATA; core_lat = T - 1; core_resp = RESP2;
        press(3*D, 3*D);
        check("edge_done_res", result, RESP2);
        check("edge_done_err", 64'(error), 64'd0);

        // done one cycle too late lands in ERR and is ignored
        press(3*D, 3*D);
        core_lat = T; core_resp = RESP3;
        press(3*D, 3*D);
        check("late_done_err", 64'(error), 64'd1);
        check("late_done_res", result, RESP2);
        press(3*D, 3*D);
        check("late_restart", 64'(state_dbg), 64'd1);

        // Debounce: D-1 cycle glitch is not a press
        entry_values = KEY2; core_lat = 0;
        press(D - 1, 3*D);
        check("glitch_state", 64'(state_dbg), 64'd1);
        check("glitch_key", des_key, KEY);
        press(3*D, 0);
        check("hold_state", 64'(state_dbg), 64'd3);
        check("hold_key", des_key, KEY2);
        check("hold_no_start", 64'(starts), 64'd0);
        go_btn_n = 1'b1;
        repeat (3*D) @(negedge clk);

        // Reset during WAIT, late done afterwards
        entry_values = DATA; core_resp = RESP4;
        go_btn_n = 1'b0;
        begin
            int waited = 0;
            while (!des_start && waited < 4*D) begin @(negedge clk); waited++; end
            check("rst_reach_start", 64'(des_start), 64'd1);
        end
        repeat (2) @(negedge clk);
        go_btn_n = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_async_state", 64'(state_dbg), 64'd0);
        check("rst_async_res", result, 64'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_release_state", 64'(state_dbg), 64'd0);
        @(negedge clk);
        extra_done = 1'b1;
        @(negedge clk);
        extra_done = 1'b0;
        repeat (3) @(negedge clk);
        check("late_done_after_rst", result, 64'd0);
        check("after_rst_state", 64'(state_dbg), 64'd1);

        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
